// File: rtl/ucore_pkg.sv
// Shared definitions for the ucore NoC input/output channel blocks.
package ucore_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned MAX_NUM_DEST       = 8;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;

endpackage

// File: rtl/ucore_fifo.sv
// Synchronous FIFO with registered head; storage cleared on reset so the head reads 0 while empty after reset.
module ucore_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DATA_WIDTH-1:0]    head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Power-of-two depth: pointers wrap naturally at PW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ucore_output_channels.sv
// Transmit side of a ucore NoC link: buffers results and broadcasts each head token to all
// enabled consumers, retiring it once every enabled consumer has accepted it.
module ucore_output_channels
    import ucore_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = DATA_WIDTH_DEFAULT,
    parameter int unsigned NUM_DEST            = 4,
    parameter int unsigned OUTPUT_BUFFER_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DEST-1:0]   dest_mask,
    input  logic                  core_ivalid,
    input  logic [DATA_WIDTH-1:0] core_in,
    output logic                  core_oready,
    output logic [NUM_DEST-1:0]   noc_ovalid,
    output logic [DATA_WIDTH-1:0] noc_out,
    input  logic [NUM_DEST-1:0]   noc_iready,
    output logic                  empty
);

    localparam int unsigned CW = $clog2(OUTPUT_BUFFER_DEPTH) + 1;

    logic                fifo_full, fifo_empty, push, retire;
    logic [CW-1:0]       fifo_count;
    logic [NUM_DEST-1:0] sent_q, sent_d, fire;

    ucore_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUTPUT_BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (core_in),
        .pop_i   (retire),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (noc_out)
    );

    // No pop-bypass: a full FIFO refuses input even in a cycle that retires the head.
    assign core_oready = !fifo_full;
    assign push        = core_ivalid && core_oready;
    assign empty       = fifo_empty;

    assign noc_ovalid = {NUM_DEST{!fifo_empty}} & dest_mask & ~sent_q;
    assign fire       = noc_ovalid & noc_iready;
    assign retire     = !fifo_empty && (&(sent_q | fire | ~dest_mask));

    always_comb begin
        sent_d = sent_q | fire;
        if (retire) sent_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sent_q <= '0;
        else        sent_q <= sent_d;
    end

    a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CW'(OUTPUT_BUFFER_DEPTH)));

endmodule

// File: tb/tb_ucore_output_channels.sv
// Directed vector bench for ucore_output_channels (DATA_WIDTH=32, NUM_DEST=4, depth 2).
module tb_ucore_output_channels;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dest_mask;
    logic        core_ivalid;
    logic [31:0] core_in;
    logic        core_oready;
    logic [3:0]  noc_ovalid;
    logic [31:0] noc_out;
    logic [3:0]  noc_iready;
    logic        empty;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ucore_output_channels #(
        .DATA_WIDTH          (32),
        .NUM_DEST            (4),
        .OUTPUT_BUFFER_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dest_mask   (dest_mask),
        .core_ivalid (core_ivalid),
        .core_in     (core_in),
        .core_oready (core_oready),
        .noc_ovalid  (noc_ovalid),
        .noc_out     (noc_out),
        .noc_iready  (noc_iready),
        .empty       (empty)
    );

    // Inputs applied for one cycle and the outputs expected in that same cycle (before its edge).
    typedef struct {
        logic [3:0]  dm;
        logic        iv;
        logic [31:0] din;
        logic [3:0]  rdy;
        logic        e_ordy;
        logic [3:0]  e_ov;
        logic        chk_out;
        logic [31:0] e_out;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] dm, input logic iv, input logic [31:0] din,
                       input logic [3:0] rdy, input logic e_ordy, input logic [3:0] e_ov,
                       input logic chk_out, input logic [31:0] e_out, input logic e_empty);
        vec_t v;
        v.dm = dm; v.iv = iv; v.din = din; v.rdy = rdy;
        v.e_ordy = e_ordy; v.e_ov = e_ov; v.chk_out = chk_out; v.e_out = e_out; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] dm, input logic iv, input logic [31:0] din,
                         input logic [3:0] rdy);
        @(negedge clk);
        dest_mask = dm; core_ivalid = iv; core_in = din; noc_iready = rdy;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic e_ordy, input logic [3:0] e_ov,
                            input logic chk_out, input logic [31:0] e_out, input logic e_empty);
        chk({tag, ".core_oready"}, 32'(core_oready), 32'(e_ordy));
        chk({tag, ".noc_ovalid"},  32'(noc_ovalid),  32'(e_ov));
        chk({tag, ".empty"},       32'(empty),       32'(e_empty));
        if (chk_out) chk({tag, ".noc_out"}, noc_out, e_out);
    endtask

    initial begin
        // 1: basic push and two-consumer broadcast
        add(4'b0011, 1, 32'hA5A5A5A5, 4'b0000, 1, 4'b0000, 1, 32'h0, 1);
        add(4'b0011, 0, 32'h0,        4'b0011, 1, 4'b0011, 1, 32'hA5A5A5A5, 0);
        add(4'b0011, 0, 32'h0,        4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        // 2: consumers accept in different cycles
        add(4'b0111, 1, 32'h11111111, 4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        add(4'b0111, 0, 32'h0,        4'b0001, 1, 4'b0111, 1, 32'h11111111, 0);
        add(4'b0111, 0, 32'h0,        4'b0000, 1, 4'b0110, 1, 32'h11111111, 0);
        add(4'b0111, 0, 32'h0,        4'b0100, 1, 4'b0110, 1, 32'h11111111, 0);
        add(4'b0111, 0, 32'h0,        4'b0111, 1, 4'b0010, 1, 32'h11111111, 0);
        add(4'b0111, 0, 32'h0,        4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        // 3: backpressure, full refuses input even while retiring
        add(4'b0011, 1, 32'h10000000, 4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        add(4'b0011, 1, 32'h10000001, 4'b0000, 1, 4'b0011, 1, 32'h10000000, 0);
        add(4'b0011, 1, 32'h10000002, 4'b0000, 0, 4'b0011, 1, 32'h10000000, 0);
        add(4'b0011, 1, 32'h10000002, 4'b0011, 0, 4'b0011, 1, 32'h10000000, 0);
        add(4'b0011, 1, 32'h10000002, 4'b0000, 1, 4'b0011, 1, 32'h10000001, 0);
        add(4'b0011, 0, 32'h0,        4'b0011, 0, 4'b0011, 1, 32'h10000001, 0);
        add(4'b0011, 0, 32'h0,        4'b0011, 1, 4'b0011, 1, 32'h10000002, 0);
        add(4'b0011, 0, 32'h0,        4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        // 4: full throughput, one token per cycle after one cycle of latency
        for (int k = 0; k < 8; k++)
            add(4'b1111, 1, 32'(k), 4'b1111, 1, (k == 0) ? 4'b0000 : 4'b1111,
                k != 0, 32'(k - 1), k == 0);
        add(4'b1111, 0, 32'h0, 4'b1111, 1, 4'b1111, 1, 32'h7, 0);
        add(4'b1111, 0, 32'h0, 4'b0000, 1, 4'b0000, 0, 32'h0, 1);
        // 5: no consumers enabled, token dropped
        add(4'b0000, 1, 32'hDEADBEEF, 4'b1111, 1, 4'b0000, 0, 32'h0, 1);
        add(4'b0000, 0, 32'h0,        4'b1111, 1, 4'b0000, 0, 32'h0, 0);
        add(4'b0000, 0, 32'h0,        4'b1111, 1, 4'b0000, 0, 32'h0, 1);

        rst_n = 1'b0; dest_mask = 4'b0011; core_ivalid = 1'b0; core_in = '0; noc_iready = '0;
        @(negedge clk);
        #1;
        chk_outs("reset", 1, 4'b0000, 1, 32'h0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].dm, vecs[i].iv, vecs[i].din, vecs[i].rdy);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ordy, vecs[i].e_ov,
                     vecs[i].chk_out, vecs[i].e_out, vecs[i].e_empty);
        end

        // 6: reset in the middle of a fan-out
        drive(4'b0011, 1, 32'h12345678, 4'b0000);
        chk_outs("rst6.push", 1, 4'b0000, 0, 32'h0, 1);
        drive(4'b0011, 0, 32'h0, 4'b0001);
        chk_outs("rst6.head", 1, 4'b0011, 1, 32'h12345678, 0);
        drive(4'b0011, 0, 32'h0, 4'b0000);
        chk_outs("rst6.part", 1, 4'b0010, 1, 32'h12345678, 0);
        rst_n = 1'b0;
        #1;
        chk_outs("rst6.in_rst", 1, 4'b0000, 1, 32'h0, 1);
        drive(4'b0011, 0, 32'h0, 4'b0000);
        chk_outs("rst6.in_rst2", 1, 4'b0000, 1, 32'h0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_outs("rst6.release", 1, 4'b0000, 1, 32'h0, 1);
        drive(4'b0011, 1, 32'hCAFEF00D, 4'b0000);
        chk_outs("rst6.push2", 1, 4'b0000, 0, 32'h0, 1);
        drive(4'b0011, 0, 32'h0, 4'b0011);
        chk_outs("rst6.fresh", 1, 4'b0011, 1, 32'hCAFEF00D, 0);
        drive(4'b0011, 0, 32'h0, 4'b0000);
        chk_outs("rst6.done", 1, 4'b0000, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
